// File: rtl/ssd_score_driver.sv
// Binary score to 5-digit BCD (sequential double-dabble) and multiplexed
// Nexys4 seven-segment drive on An4..An0 with optional leading-zero blanking.
module ssd_score_driver #(
   parameter int unsigned SCAN_DIV_BITS = 18,
   parameter bit          BLANK_LZ      = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] score,
   input  logic        score_valid,
   output logic        busy,
   output logic        done,
   output logic [7:0]  an,
   output logic [7:0]  seg
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_e;

   localparam logic [SCAN_DIV_BITS-1:0] DIV_ONE = SCAN_DIV_BITS'(1);

   state_e                   state_q;
   logic [35:0]              shift_q, shift_adj;
   logic [3:0]               cnt_q;
   logic                     pend_q;
   logic [15:0]              pend_val_q;
   logic                     busy_q, done_q;
   logic [19:0]              dig_q;
   logic [SCAN_DIV_BITS-1:0] div_q;
   logic [2:0]               idx_q;
   logic [7:0]               an_q, an_d, seg_q, seg_d;
   logic [3:0]               cur_nib;
   logic [7:0]               blank_v;
   logic                     blanked;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // Add-3 on every BCD nibble >= 5 before the shift.
   always_comb begin
      shift_adj = shift_q;
      for (int unsigned i = 0; i < 5; i++) begin
         if (shift_q[16+4*i +: 4] >= 4'd5)
            shift_adj[16+4*i +: 4] = shift_q[16+4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dig_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (score_valid) begin
                  shift_q <= {20'b0, score};
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               shift_q <= shift_adj << 1;
               cnt_q   <= cnt_q + 4'd1;
               if (cnt_q == 4'd15)
                  state_q <= S_COMMIT;
               if (score_valid) begin
                  pend_q     <= 1'b1;
                  pend_val_q <= score;
               end
            end
            S_COMMIT: begin
               dig_q  <= shift_q[35:16];
               done_q <= 1'b1;
               pend_q <= 1'b0;
               // A strobe landing on the commit cycle is newer than any pending value.
               if (score_valid || pend_q) begin
                  shift_q <= {20'b0, (score_valid ? score : pend_val_q)};
                  cnt_q   <= '0;
                  state_q <= S_SHIFT;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         idx_q <= '0;
      end else begin
         div_q <= div_q + DIV_ONE;
         if (&div_q)
            idx_q <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
      end
   end

   always_comb begin
      blank_v    = '0;
      blank_v[4] = (dig_q[19:16] == 4'd0);
      blank_v[3] = blank_v[4] && (dig_q[15:12] == 4'd0);
      blank_v[2] = blank_v[3] && (dig_q[11:8] == 4'd0);
      blank_v[1] = blank_v[2] && (dig_q[7:4] == 4'd0);
      blanked    = BLANK_LZ && blank_v[idx_q];
      case (idx_q)
         3'd1:    cur_nib = dig_q[7:4];
         3'd2:    cur_nib = dig_q[11:8];
         3'd3:    cur_nib = dig_q[15:12];
         3'd4:    cur_nib = dig_q[19:16];
         default: cur_nib = dig_q[3:0];
      endcase
      an_d  = 8'hFF;
      seg_d = 8'hFF;
      if (!blanked) begin
         an_d[idx_q] = 1'b0;
         seg_d       = {seg7(cur_nib), 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q  <= 8'hFF;
         seg_q <= 8'hFF;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign an   = an_q;
   assign seg  = seg_q;

endmodule

// File: tb/tb_ssd_score_driver.sv
// Scoreboard bench for ssd_score_driver: two instances (blanking on/off) share
// randomized and directed score strobes; a high-level model predicts commits.
module tb_ssd_score_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] score = '0;
   logic        score_valid = 1'b0;
   logic        busy_a, done_a, busy_b, done_b;
   logic [7:0]  an_a, seg_a, an_b, seg_b;

   always #5 clk = ~clk;

   ssd_score_driver #(.SCAN_DIV_BITS(2), .BLANK_LZ(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
      .busy(busy_a), .done(done_a), .an(an_a), .seg(seg_a));

   ssd_score_driver #(.SCAN_DIV_BITS(2), .BLANK_LZ(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
      .busy(busy_b), .done(done_b), .an(an_b), .seg(seg_b));

   logic [6:0]  SEG7 [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
   int unsigned P10 [5] = '{1, 10, 100, 1000, 10000};

   typedef struct { int unsigned val; int unsigned cyc; } exp_t;
   exp_t exp_q [$];

   int unsigned n_chk = 0, n_pass = 0;
   int unsigned cyc = 0;
   bit          m_active = 0, m_pend = 0, m_busy = 0;
   int unsigned m_cur = 0, m_pval = 0, m_due = 0;

   // Stimulus-owned control
   int unsigned n_tout = 0;
   int unsigned win_seq = 0;
   logic [4:0]  win_mask_a = '0;
   bit          fin_req = 0;

   function automatic logic [4:0] nz_mask(input int unsigned v);
      nz_mask[0] = 1'b1;
      for (int k = 1; k < 5; k++) nz_mask[k] = (v >= P10[k]);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic chk_disp(input string nm, input logic [7:0] a, input logic [7:0] s,
                           input int unsigned v, input bit blz);
      int          k;
      int unsigned d;
      bit          blanked;
      logic [7:0]  ea, es;
      k = -1;
      for (int i = 0; i < 8; i++) if (a[i] == 1'b0 && k < 0) k = i;
      if (k < 0) begin
         chk({nm, "_dark_seg"}, s, 8'hFF);
      end else if (k > 4) begin
         chk({nm, "_an"}, a, 8'hFF);
      end else begin
         d       = (v / P10[k]) % 10;
         blanked = blz && (k >= 1) && (v < P10[k]);
         ea      = blanked ? 8'hFF : ~(8'h01 << k);
         es      = blanked ? 8'hFF : {SEG7[d], 1'b1};
         chk({nm, "_an"}, a, ea);
         chk({nm, "_seg"}, s, es);
      end
   endtask

   // Reference model: conversion schedule with single-entry latest-wins pending slot.
   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_active = 0;
         m_pend   = 0;
      end else if (m_active && cyc == m_due) begin
         exp_q.push_back('{val: m_cur, cyc: cyc});
         if (score_valid) begin
            m_cur = score; m_due = cyc + 17;
         end else if (m_pend) begin
            m_cur = m_pval; m_due = cyc + 17;
         end else begin
            m_active = 0;
         end
         m_pend = 0;
      end else if (score_valid) begin
         if (!m_active) begin
            m_active = 1; m_cur = score; m_due = cyc + 17;
         end else begin
            m_pend = 1; m_pval = score;
         end
      end
      m_busy = m_active;
   end

   // Monitor
   int unsigned disp = 0;
   int          last_b = -1, cur_b;
   int unsigned cnt_a [5] = '{0, 0, 0, 0, 0};
   int unsigned cnt_b [5] = '{0, 0, 0, 0, 0};
   int unsigned snap_a [5], snap_b [5];
   int unsigned win_ack = 0, win_left = 0;
   bit          has_exp;
   logic [4:0]  seen_a, seen_b;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_an_a", an_a, 8'hFF);   chk("rst_seg_a", seg_a, 8'hFF);
         chk("rst_an_b", an_b, 8'hFF);   chk("rst_seg_b", seg_b, 8'hFF);
         chk("rst_busy_a", busy_a, 1'b0); chk("rst_done_a", done_a, 1'b0);
         chk("rst_busy_b", busy_b, 1'b0); chk("rst_done_b", done_b, 1'b0);
         disp   = 0;
         last_b = -1;
      end else begin
         chk("busy_a", busy_a, m_busy);
         chk("busy_b", busy_b, m_busy);
         has_exp = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
         chk("done_a", done_a, has_exp);
         chk("done_b", done_b, has_exp);
         chk_disp("disp_a", an_a, seg_a, disp, 1'b1);
         chk_disp("disp_b", an_b, seg_b, disp, 1'b0);
         cur_b = -1;
         for (int k = 0; k < 5; k++) begin
            if (!an_a[k]) cnt_a[k]++;
            if (!an_b[k]) begin cnt_b[k]++; cur_b = k; end
         end
         if (cur_b >= 0 && last_b >= 0 && cur_b != last_b)
            chk("scan_order_b", cur_b, (last_b + 1) % 5);
         if (cur_b >= 0) last_b = cur_b;
         if (has_exp) begin
            disp = exp_q[0].val;
            void'(exp_q.pop_front());
         end
         if (win_seq != win_ack) begin
            win_ack = win_seq;
            for (int k = 0; k < 5; k++) begin snap_a[k] = cnt_a[k]; snap_b[k] = cnt_b[k]; end
            win_left = 24;
         end else if (win_left > 0) begin
            win_left--;
            if (win_left == 0) begin
               for (int k = 0; k < 5; k++) begin
                  seen_a[k] = (cnt_a[k] != snap_a[k]);
                  seen_b[k] = (cnt_b[k] != snap_b[k]);
               end
               chk("scan_mask_a", seen_a, win_mask_a);
               chk("scan_mask_b", seen_b, 5'h1F);
            end
         end
      end
      if (fin_req) begin
         chk("idle_timeouts", n_tout, 0);
         chk("unmatched_commits", exp_q.size(), 0);
         $display("%0d/%0d checks passed", n_pass, n_chk);
         $finish;
      end
   end

   task automatic strobe(input logic [15:0] v);
      @(negedge clk);
      score = v; score_valid = 1'b1;
      @(negedge clk);
      score_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (!m_busy && exp_q.size() == 0 && !busy_a) ok = 1;
      end
      if (!ok) n_tout++;
      repeat (3) @(negedge clk);
   endtask

   task automatic scan_window(input int unsigned v);
      win_mask_a = nz_mask(v);
      win_seq++;
      repeat (28) @(negedge clk);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      scan_window(0);

      strobe(16'd12345);  wait_idle(); scan_window(12345);
      strobe(16'd65535);  wait_idle(); scan_window(65535);
      strobe(16'd7);      wait_idle(); scan_window(7);

      strobe(16'd100);
      repeat (3) @(negedge clk); strobe(16'd200);
      repeat (3) @(negedge clk); strobe(16'd300);
      wait_idle(); scan_window(300);

      strobe(16'd500);
      repeat (16) @(negedge clk);
      score = 16'd42; score_valid = 1'b1;
      @(negedge clk);
      score_valid = 1'b0;
      wait_idle(); scan_window(42);

      strobe(16'd1234);
      strobe(16'd999);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b1;
      wait_idle(); scan_window(0);

      for (int n = 0; n < 30; n++) begin
         repeat ($urandom_range(0, 22)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) strobe(16'($urandom_range(0, 99)));
         else                           strobe(16'($urandom_range(0, 65535)));
      end
      wait_idle();
      fin_req = 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
